// File: rtl/cpu_mem_wb.sv
// -----------------------------------------------------------------------------
// cpu_mem_wb -- combined MEM/WB pipeline stage of a small 16-bit CPU.
//
// Takes an instruction from EX. ALU-only instructions retire one cycle later.
// Loads and stores enter a WAIT state that holds a request on the data-memory
// port until memReady is seen. A 4-bit watchdog abandons an access that gets
// no memReady and sets a sticky error flag.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   valid_in             instruction from EX present this cycle
//   aluResult            ALU result / effective address
//   storeData            store data
//   destReg              destination register (R0 is hardwired zero)
//   MEMcontrols          {memRead, memWrite}
//   WBcontrols           {memToReg, regWriteEn}
//   memRdData, memReady  data-memory response
//   memAddr, memWrData   data-memory request address / write data
//   memEn, memWr         request strobe (held until memReady), 1=write
//   stall                upstream must hold its next instruction
//   wrData, regWriteIncomingAddr, regWriteControl   register-file write port
//   memError             sticky memory-timeout flag
// -----------------------------------------------------------------------------
module cpu_mem_wb #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] storeData,
  input  logic [REG_W-1:0]  destReg,
  input  logic [1:0]        MEMcontrols,
  input  logic [1:0]        WBcontrols,
  input  logic [DATA_W-1:0] memRdData,
  input  logic              memReady,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWrData,
  output logic              memEn,
  output logic              memWr,
  output logic              stall,
  output logic [DATA_W-1:0] wrData,
  output logic [REG_W-1:0]  regWriteIncomingAddr,
  output logic              regWriteControl,
  output logic              memError
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic [DATA_W-1:0]   wrData_q;
  logic [REG_W-1:0]    wrAddr_q;
  logic                regWc_q;
  logic                memErr_q;

  // Instruction captured on entry to WAIT; only meaningful while in WAIT,
  // so these carry no reset.
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   sdata_q;
  logic [REG_W-1:0]    dest_q;
  logic                store_q;
  logic                memToReg_q;
  logic                regWe_q;

  logic                mem_op_d;
  logic                accept_mem_d;
  logic [DATA_W-1:0]   ld_data_d;

  assign mem_op_d     = MEMcontrols[1] | MEMcontrols[0];
  assign accept_mem_d = (state_q == IDLE) && valid_in && mem_op_d;
  // memToReg=0 on a load writes back the address itself.
  assign ld_data_d    = memToReg_q ? memRdData : addr_q;

  // ---- capture stage: latch the memory instruction on accept ----
  always_ff @(posedge clk) begin
    if (accept_mem_d) begin
      addr_q     <= aluResult;
      sdata_q    <= storeData;
      dest_q     <= destReg;
      // memWrite wins, so memRead=memWrite=1 behaves as a store.
      store_q    <= MEMcontrols[0];
      memToReg_q <= WBcontrols[1];
      regWe_q    <= WBcontrols[0];
    end
  end

  // ---- control FSM and writeback registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      wrData_q <= '0;
      wrAddr_q <= '0;
      regWc_q  <= 1'b0;
      memErr_q <= 1'b0;
    end else begin
      // Write enable is a single-cycle pulse unless re-asserted below.
      regWc_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            if (mem_op_d) begin
              state_q <= WAIT;
              cnt_q   <= 4'd0;
            end else begin
              wrData_q <= aluResult;
              wrAddr_q <= destReg;
              regWc_q  <= WBcontrols[0] && (destReg != '0);
            end
          end
        end
        WAIT: begin
          // A response in the final watchdog cycle still completes normally.
          if (memReady) begin
            state_q <= IDLE;
            if (!store_q) begin
              wrData_q <= ld_data_d;
              wrAddr_q <= dest_q;
              regWc_q  <= regWe_q && (dest_q != '0);
            end
          end else if (cnt_q == 4'hF) begin
            state_q  <= IDLE;
            memErr_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory port is a pure decode of the registered state, so reset drops
  // the request immediately.
  assign stall                = (state_q == WAIT);
  assign memEn                = (state_q == WAIT);
  assign memWr                = (state_q == WAIT) && store_q;
  assign memAddr              = (state_q == WAIT) ? addr_q  : '0;
  assign memWrData            = (state_q == WAIT) ? sdata_q : '0;
  assign wrData               = wrData_q;
  assign regWriteIncomingAddr = wrAddr_q;
  assign regWriteControl      = regWc_q;
  assign memError             = memErr_q;

endmodule
